or_gate_16: RTL and testbench



---
 rtl/or_gate_16.sv | 77 +++++++
 tb/tb_or_gate_16.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/or_gate_16.sv
// ---------------------------------------------------------------------------
// or_gate_16
// Registered bitwise-OR unit used by the ALU for its OR operation.
// It computes out = a | b and registers the result with a latency of one
// cycle. It also registers zero/all-ones status flags for the ALU flag logic.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operands a/b are valid this cycle
//   a, b       WIDTH-bit operands
//   out        registered result a | b (holds until the next accepted operand)
//   out_valid  out was captured on the previous edge (one-cycle pulse per op)
//   zero       registered: captured result is all zeros
//   ones       registered: captured result is all ones
// ---------------------------------------------------------------------------
module or_gate_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             ones
);

  function automatic logic all_zero(input logic [WIDTH-1:0] v);
    return ~(|v);
  endfunction

  function automatic logic all_ones(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  // ---- stage p0: combinational OR and flag reduction ----
  logic [WIDTH-1:0] or_p0;
  logic             zero_p0;
  logic             ones_p0;

  assign or_p0   = a | b;
  assign zero_p0 = all_zero(or_p0);
  assign ones_p0 = all_ones(or_p0);

  // ---- stage p1: result, flags and valid registers ----
  logic [WIDTH-1:0] out_p1;
  logic             zero_p1;
  logic             ones_p1;
  logic             vld_p1;

  // The data registers are reset as well, so every output is defined from
  // reset onward. The reset value of zero is 1 because it describes out == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1  <= '0;
      zero_p1 <= 1'b1;
      ones_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        out_p1  <= or_p0;
        zero_p1 <= zero_p0;
        ones_p1 <= ones_p0;
      end
    end
  end

  assign out       = out_p1;
  assign zero      = zero_p1;
  assign ones      = ones_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_or_gate_16.sv
module tb_or_gate_16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] out;
  logic        out_valid;
  logic        zero;
  logic        ones;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entry packs {out, zero, ones}.
  logic [17:0] sb[$];
  logic [17:0] held;

  or_gate_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out(out), .out_valid(out_valid), .zero(zero), .ones(ones)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) r[i] = av[i] | bv[i];
    return {r, (r == 16'h0000), (r == 16'hFFFF)};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_out"},  {16'h0, out},  {16'h0, held[17:2]});
    chk({tag, "_zero"}, {31'h0, zero}, {31'h0, held[1]});
    chk({tag, "_ones"}, {31'h0, ones}, {31'h0, held[0]});
  endtask

  // Drive one cycle (called just after a rising edge), then check after the next edge.
  task automatic step(input string tag, input logic v, input logic [15:0] av, input logic [15:0] bv);
    in_valid = v;
    a = av;
    b = bv;
    if (v) sb.push_back(model(av, bv));
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {31'h0, out_valid}, {31'h0, v});
    if (out_valid) begin
      if (sb.size() == 0) chk({tag, "_spurious"}, 32'd1, 32'd0);
      else held = sb.pop_front();
    end
    check_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    held = {16'h0000, 1'b1, 1'b0};
    chk({tag, "_vld"}, {31'h0, out_valid}, 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    held = {16'h0000, 1'b1, 1'b0};
    // Power-on async reset
    #2 rst = 1'b1;
    #1 check_reset_state("por");
    @(posedge clk); #1;
    rst = 1'b0;
    step("idle0", 1'b0, 16'hAAAA, 16'h5555);

    // Mid-cycle async reset after some live state
    step("pre", 1'b1, 16'h00F0, 16'h0F00);
    #3 rst = 1'b1;
    #1 check_reset_state("async_rst");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst", 1'b0, 16'h1111, 16'h2222);

    // Directed vectors
    step("v1", 1'b1, 16'h0000, 16'h0001);
    step("v2", 1'b1, 16'h000E, 16'h0015);
    step("v3", 1'b1, 16'h0003, 16'h00DD);
    step("fz", 1'b1, 16'h0000, 16'h0000);
    step("fo", 1'b1, 16'hFF00, 16'h00FF);
    chk("fo_value", {16'h0, out}, 32'h0000FFFF);

    // Hold while in_valid is low
    step("hold_ld", 1'b1, 16'h1234, 16'h0F0F);
    chk("hold_value", {16'h0, out}, 32'h00001F3F);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 16'($urandom), 16'($urandom));
    chk("hold_after", {16'h0, out}, 32'h00001F3F);

    // Back-to-back stream
    step("bb1", 1'b1, 16'h0101, 16'h1010);
    step("bb2", 1'b1, 16'h8000, 16'h0001);
    step("bb3", 1'b1, 16'hFFFF, 16'h0000);
    step("gap", 1'b0, 16'h0000, 16'h0000);

    // Stream interrupted by reset during the second operand
    step("st1", 1'b1, 16'h00AA, 16'h0055);
    in_valid = 1'b1;
    a = 16'h7000;
    b = 16'h0007;
    #3 rst = 1'b1;
    #1 check_reset_state("st_rst");
    sb.delete();
    @(posedge clk); #1;
    check_reset_state("st_rst_edge");
    in_valid = 1'b0;
    rst = 1'b0;
    step("st_idle1", 1'b0, 16'h7000, 16'h0007);
    step("st_idle2", 1'b0, 16'h0F00, 16'h00F0);
    step("st3", 1'b1, 16'h0C00, 16'h00C0);

    // Randomized
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rv;
      int          sel;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      sel = int'($urandom_range(0, 15));
      if (sel == 0) begin ra = 16'h0000; rb = 16'h0000; end
      if (sel == 1) begin ra = 16'hF0F0; rb = 16'h0F0F; end
      rv = ($urandom_range(0, 3) != 0);
      step("rnd", rv, ra, rb);
    end
    step("final", 1'b0, 16'h0000, 16'h0000);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
